// File: rtl/unencoded_tcam_resp.sv
// Ternary CAM with an unencoded per-entry hit vector; UNENCODED_TCAM_FAST_WR_EN gives single-edge writes.
// Latency: lookup result registered, visible one cycle after the key is sampled; writes take WR_LAT cycles.
// Backpressure: none on lookups; cam_busy high during a write, and writes requested while busy are dropped.
module unencoded_tcam_resp #(
  parameter int CMP_WIDTH  = 32,
  parameter int DEPTH      = 16,
  parameter int DEPTH_BITS = $clog2(DEPTH),
  parameter int WR_LAT     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CMP_WIDTH-1:0]  cam_cmp_din,
  input  logic [CMP_WIDTH-1:0]  cam_cmp_data_mask,
  input  logic                  cam_we,
  input  logic [DEPTH_BITS-1:0] cam_wr_addr,
  input  logic [CMP_WIDTH-1:0]  cam_din,
  input  logic [CMP_WIDTH-1:0]  cam_data_mask,
  output logic                  cam_busy,
  output logic                  cam_match,
  output logic [DEPTH-1:0]      cam_match_addr
);

  logic [CMP_WIDTH-1:0] ent_data [DEPTH];
  logic [CMP_WIDTH-1:0] ent_mask [DEPTH];
  logic [DEPTH-1:0]     ent_vld;
  logic [DEPTH-1:0]     hit;
  logic                 addr_ok;
  logic                 wr_ok;

  // Range check is only needed when the address field can name missing entries.
  generate
    if ((2 ** DEPTH_BITS) > DEPTH) begin : g_addr_chk
      localparam logic [DEPTH_BITS:0] DEPTH_LIM = (DEPTH_BITS + 1)'(DEPTH);
      assign addr_ok = ({1'b0, cam_wr_addr} < DEPTH_LIM);
    end else begin : g_addr_full
      assign addr_ok = 1'b1;
    end
  endgenerate

  assign wr_ok = cam_we && !cam_busy && addr_ok;

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = ent_vld[i] &&
               (((ent_data[i] ^ cam_cmp_din) & ~ent_mask[i] & ~cam_cmp_data_mask) == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cam_match_addr <= '0;
      cam_match      <= 1'b0;
    end else begin
      cam_match_addr <= hit;
      cam_match      <= |hit;
    end
  end

`ifdef UNENCODED_TCAM_FAST_WR_EN

  assign cam_busy = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_vld <= '0;
    end else if (wr_ok) begin
      ent_vld[cam_wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      ent_data[cam_wr_addr] <= cam_din;
      ent_mask[cam_wr_addr] <= cam_data_mask;
    end
  end

`else

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q;
  logic [DEPTH_BITS-1:0] wr_addr_q;
  logic [CMP_WIDTH-1:0]  wr_din_q;
  logic [CMP_WIDTH-1:0]  wr_mask_q;
  logic                  commit;

  // The edge ending the last busy cycle stores the entry.
  assign commit = (state_q == WRITE) && (cnt_q == 8'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_ok)  state_d = WRITE;
      WRITE:   if (commit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cam_busy = (state_q == WRITE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
    end else if (wr_ok) begin
      cnt_q <= 8'(WR_LAT);
    end else if (state_q == WRITE) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      wr_addr_q <= cam_wr_addr;
      wr_din_q  <= cam_din;
      wr_mask_q <= cam_data_mask;
    end
  end

  // Target drops out of lookups from the accepting edge until the store edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_vld <= '0;
    end else if (wr_ok) begin
      ent_vld[cam_wr_addr] <= 1'b0;
    end else if (commit) begin
      ent_vld[wr_addr_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      ent_data[wr_addr_q] <= wr_din_q;
      ent_mask[wr_addr_q] <= wr_mask_q;
    end
  end

`endif

endmodule

// File: tb/tb_unencoded_tcam_resp.sv
// Scoreboard bench for unencoded_tcam_resp (default geometry); also covers UNENCODED_TCAM_FAST_WR_EN builds.
module tb_unencoded_tcam_resp;

  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int WRL   = 16;
`ifdef UNENCODED_TCAM_FAST_WR_EN
  localparam int EXP_BUSY_LEN = 0;
`else
  localparam int EXP_BUSY_LEN = WRL;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [W-1:0]     cam_cmp_din, cam_cmp_data_mask, cam_din, cam_data_mask;
  logic             cam_we;
  logic [3:0]       cam_wr_addr;
  logic             cam_busy, cam_match;
  logic [DEPTH-1:0] cam_match_addr;

  unencoded_tcam_resp #(.CMP_WIDTH(W), .DEPTH(DEPTH), .DEPTH_BITS(4), .WR_LAT(WRL)) dut (
    .clk(clk), .reset_n(reset_n),
    .cam_cmp_din(cam_cmp_din), .cam_cmp_data_mask(cam_cmp_data_mask),
    .cam_we(cam_we), .cam_wr_addr(cam_wr_addr), .cam_din(cam_din), .cam_data_mask(cam_data_mask),
    .cam_busy(cam_busy), .cam_match(cam_match), .cam_match_addr(cam_match_addr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference contents and write timing
  logic [W-1:0]     m_data [DEPTH];
  logic [W-1:0]     m_mask [DEPTH];
  logic [DEPTH-1:0] m_valid;
  int               m_cnt;
  logic [3:0]       m_addr;
  logic [W-1:0]     m_din, m_dmask;
  logic [DEPTH:0]   sb [$];
  logic [DEPTH-1:0] last_ma;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DEPTH-1:0] exp_hits(input logic [W-1:0] key, input logic [W-1:0] kmask);
    logic [DEPTH-1:0] h;
    h = '0;
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && (((m_data[i] ^ key) & ~m_mask[i] & ~kmask) == '0)) h[i] = 1'b1;
    return h;
  endfunction

  task automatic model_edge(input logic we, input logic [3:0] addr, input logic [W-1:0] d, input logic [W-1:0] m);
`ifdef UNENCODED_TCAM_FAST_WR_EN
    if (we) begin
      m_data[addr] = d; m_mask[addr] = m; m_valid[addr] = 1'b1;
    end
`else
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_data[m_addr] = m_din; m_mask[m_addr] = m_dmask; m_valid[m_addr] = 1'b1;
      end
    end else if (we) begin
      m_valid[addr] = 1'b0;
      m_addr = addr; m_din = d; m_dmask = m; m_cnt = WRL;
    end
`endif
  endtask

  // One clock: drive, predict, advance, then compare the registered result
  task automatic step(input logic [W-1:0] key, input logic [W-1:0] kmask, input logic we,
                      input logic [3:0] addr, input logic [W-1:0] d, input logic [W-1:0] m);
    logic [DEPTH-1:0] h;
    logic [DEPTH:0]   e;
    cam_cmp_din = key; cam_cmp_data_mask = kmask;
    cam_we = we; cam_wr_addr = addr; cam_din = d; cam_data_mask = m;
    h = exp_hits(key, kmask);
    sb.push_back({h, |h});
    model_edge(we, addr, d, m);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("match_addr", 32'(cam_match_addr), 32'(e[DEPTH:1]));
    chk("match", 32'(cam_match), 32'(e[0]));
    chk("busy", 32'(cam_busy), 32'(m_cnt > 0));
    last_ma = cam_match_addr;
    cam_we = 1'b0;
  endtask

  task automatic wait_idle(input logic [W-1:0] key);
    int n = 0;
    while (cam_busy && n < 64) begin
      step(key, '0, 1'b0, 4'd0, '0, '0);
      n++;
    end
    chk("wait_idle_timeout", 32'(cam_busy), 32'd0);
  endtask

  task automatic model_reset();
    m_valid = '0; m_cnt = 0;
  endtask

  initial begin
    int busy_len;
    int guard;
    logic [W-1:0] keys [6];
    logic [W-1:0] kms  [3];

    for (int i = 0; i < DEPTH; i++) begin m_data[i] = '0; m_mask[i] = '0; end
    model_reset();
    last_ma = '0;
    reset_n = 1'b0;
    cam_cmp_din = '0; cam_cmp_data_mask = '0; cam_we = 1'b0;
    cam_wr_addr = '0; cam_din = '0; cam_data_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(cam_busy), 32'd0);
    chk("rst_match", 32'(cam_match), 32'd0);
    chk("rst_match_addr", 32'(cam_match_addr), 32'd0);
    reset_n = 1'b1;

    step(32'h0000_0001, '0, 1'b0, 4'd0, '0, '0);
    chk("first_lookup_addr", 32'(last_ma), 32'h0000);
    chk("first_lookup_match", 32'(cam_match), 32'd0);

`ifdef UNENCODED_TCAM_FAST_WR_EN
    step(32'h0000_00C0, '0, 1'b1, 4'd0, 32'h0000_00C0, '0);
    chk("fast_busy0", 32'(cam_busy), 32'd0);
    chk("fast_e0_bit0", 32'(last_ma[0]), 32'd0);
    step(32'h0000_00C0, '0, 1'b0, 4'd0, '0, '0);
    chk("fast_busy1", 32'(cam_busy), 32'd0);
    chk("fast_e1_bit0", 32'(last_ma[0]), 32'd1);
`endif

    // Entry 3 write: measure busy window, then look it up
    step(32'h0A00_0001, '0, 1'b1, 4'd3, 32'h0A00_0001, '0);
    busy_len = cam_busy ? 1 : 0;
    guard = 0;
    while (cam_busy && guard < 64) begin
      step(32'h0A00_0001, '0, 1'b0, 4'd0, '0, '0);
      if (cam_busy) busy_len++;
      guard++;
    end
    chk("busy_len", 32'(busy_len), 32'(EXP_BUSY_LEN));
    step(32'h0A00_0001, '0, 1'b0, 4'd0, '0, '0);
    chk("entry3_hit", 32'(last_ma), 32'h0008);
    chk("entry3_match", 32'(cam_match), 32'd1);

    step(32'h0A00_0001, '0, 1'b1, 4'd2, 32'h0A00_0000, 32'h0000_00FF);
    wait_idle(32'h0A00_0001);
    step(32'h0A00_0001, '0, 1'b0, 4'd0, '0, '0);
    chk("multi_hit", 32'(last_ma), 32'h000C);

`ifndef UNENCODED_TCAM_FAST_WR_EN
    // Rewrite entry 3 while looking up every cycle; a write to 5 lands mid-window
    step(32'h0A00_0001, '0, 1'b1, 4'd3, 32'h0B00_0000, '0);
    chk("rw_e0_bit3", 32'(last_ma[3]), 32'd1);
    chk("rw_e0_bit2", 32'(last_ma[2]), 32'd1);
    for (int k = 1; k <= WRL; k++) begin
      step(32'h0A00_0001, '0, (k == 3), 4'd5, 32'h1234_5678, '0);
      chk("rw_win_bit3", 32'(last_ma[3]), 32'd0);
      chk("rw_win_bit2", 32'(last_ma[2]), 32'd1);
    end
    step(32'h0A00_0001, '0, 1'b1, 4'd7, 32'h0000_0077, '0);
    chk("back_to_back_busy", 32'(cam_busy), 32'd1);
    chk("rw_new_bit3", 32'(last_ma[3]), 32'd0);
    wait_idle(32'h0B00_0000);
    step(32'h1234_5678, '0, 1'b0, 4'd0, '0, '0);
    chk("ignored_entry5", 32'(last_ma[5]), 32'd0);
`endif

    keys[0] = 32'h0A00_0001; keys[1] = 32'h0A00_00FF; keys[2] = 32'h0B00_0000;
    keys[3] = 32'h0000_0077; keys[4] = 32'h1234_5678; keys[5] = 32'h0A00_0000;
    kms[0] = '0; kms[1] = 32'h0000_00FF; kms[2] = 32'hFFFF_0000;
    for (int i = 0; i < 24; i++)
      step(keys[$urandom_range(5)], kms[$urandom_range(2)], 1'b0, 4'd0, '0, '0);

    // Reset in the middle of a write
    step(32'h0A00_0001, '0, 1'b1, 4'd9, 32'h0000_0099, '0);
    step(32'h0A00_0001, '0, 1'b0, 4'd0, '0, '0);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(cam_busy), 32'd0);
    chk("midrst_match_addr", 32'(cam_match_addr), 32'd0);
    chk("midrst_match", 32'(cam_match), 32'd0);
    model_reset();
    sb.delete();
    #2;
    reset_n = 1'b1;
    step(32'h0000_0011, '0, 1'b1, 4'd1, 32'h0000_0011, '0);
    chk("post_rst_accept", 32'(cam_busy), 32'(EXP_BUSY_LEN > 0));
    wait_idle(32'h0000_0011);
    step(32'h0000_0011, '0, 1'b0, 4'd0, '0, '0);
    chk("post_rst_only_entry1", 32'(last_ma), 32'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
